// File: rtl/matvec_engine.sv
// rtl/matvec_engine.sv - ROWS x COLS matrix-vector multiply engine with Avalon-MM read master and streamed results
module matvec_engine #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int ADDR_WIDTH = 32,
  parameter int SIGNED     = 0,
  localparam int IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_WIDTH-1:0]      address,
  output logic                       read,
  input  logic [COLS*DATA_WIDTH-1:0] readdata,
  input  logic                       readdatavalid,
  input  logic                       waitrequest,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [IDX_W-1:0]           result_idx,
  output logic [ACC_WIDTH-1:0]       result_data
);
  localparam int CNT_W = $clog2(ROWS + 2);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ROWS);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
  localparam logic [IDX_W-1:0] LAST_ROW  = IDX_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, CALC, DRAIN} state_t;

  state_t                     state;
  logic [ADDR_WIDTH-1:0]      base_q;
  logic [CNT_W-1:0]           issue_cnt;
  logic [CNT_W-1:0]           beat_cnt;
  logic [COL_W-1:0]           col_cnt;
  logic [COLS*DATA_WIDTH-1:0] b_reg;
  logic [COLS*DATA_WIDTH-1:0] a_buf    [ROWS];
  logic [ACC_WIDTH-1:0]       acc      [ROWS];
  logic [ACC_WIDTH-1:0]       acc_next [ROWS];
  logic [DATA_WIDTH-1:0]      b_el;
  logic [IDX_W-1:0]           row_next;
  logic [ACC_WIDTH-1:0]       acc_sel;

  // Operands are widened to the accumulator width before the multiply so the
  // product and the running sum both wrap modulo 2^ACC_WIDTH.
  function automatic logic [ACC_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] v);
    if (SIGNED != 0) return {{(ACC_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    return {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, v};
  endfunction

  always_comb begin
    b_el = b_reg[col_cnt*DATA_WIDTH +: DATA_WIDTH];
    for (int r = 0; r < ROWS; r++)
      acc_next[r] = acc[r] + extend(a_buf[r][col_cnt*DATA_WIDTH +: DATA_WIDTH]) * extend(b_el);
  end

  assign row_next = result_idx + IDX_W'(1);

  always_comb begin
    acc_sel = '0;
    for (int r = 0; r < ROWS; r++)
      if (row_next == IDX_W'(r)) acc_sel = acc[r];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      read         <= 1'b0;
      address      <= '0;
      base_q       <= '0;
      issue_cnt    <= '0;
      beat_cnt     <= '0;
      col_cnt      <= '0;
      result_valid <= 1'b0;
      result_idx   <= '0;
      result_data  <= '0;
      for (int r = 0; r < ROWS; r++) acc[r] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FETCH;
            busy       <= 1'b1;
            read       <= 1'b1;
            address    <= base_addr;
            base_q     <= base_addr;
            issue_cnt  <= '0;
            beat_cnt   <= '0;
            col_cnt    <= '0;
            result_idx <= '0;
            for (int r = 0; r < ROWS; r++) acc[r] <= '0;
          end
        end
        FETCH: begin
          if (read && !waitrequest) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            if (issue_cnt == LAST_BEAT) read <= 1'b0;
            else address <= base_q + ADDR_WIDTH'(issue_cnt) + ADDR_WIDTH'(1);
          end
          // Beat 0 is the vector; beat j fills row j-1 of the matrix.
          if (readdatavalid) begin
            if (beat_cnt == '0) b_reg <= readdata;
            for (int r = 0; r < ROWS; r++)
              if (beat_cnt == CNT_W'(r + 1)) a_buf[r] <= readdata;
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_cnt == LAST_BEAT) begin
              state <= CALC;
              read  <= 1'b0;
            end
          end
        end
        CALC: begin
          for (int r = 0; r < ROWS; r++) acc[r] <= acc_next[r];
          col_cnt <= col_cnt + COL_W'(1);
          if (col_cnt == LAST_COL) begin
            state        <= DRAIN;
            result_valid <= 1'b1;
            result_idx   <= '0;
            result_data  <= acc_next[0];
          end
        end
        DRAIN: begin
          if (result_valid && result_ready) begin
            if (result_idx == LAST_ROW) begin
              state        <= IDLE;
              busy         <= 1'b0;
              done         <= 1'b1;
              result_valid <= 1'b0;
              result_idx   <= '0;
              result_data  <= '0;
            end else begin
              result_idx  <= row_next;
              result_data <= acc_sel;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
